// File: rtl/uart_pkg.sv
// Frame constants and FSM state encodings shared by the UART transceiver files.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned OVERSAMPLE = 8;
  localparam int unsigned GAP_BITS   = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divide-by-Div counter with synchronous clear; tick_o pulses on the last count.
module uart_baud_gen #(
  parameter int unsigned Div = 96
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_async_transceiver.sv
// 8N1 UART transmitter and oversampling receiver sharing one clock.
// Optional receive idle-gap detector enabled by defining UART_RX_IDLE_EN.
module uart_async_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned ClkFrequency = 11059200,
  parameter int unsigned Baud         = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_idle,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int unsigned BitDiv = ClkFrequency / Baud;
  localparam int unsigned OsDiv  = BitDiv / OVERSAMPLE;
  localparam int unsigned BitW   = $clog2(DATA_BITS);
  localparam int unsigned OsW    = $clog2(OVERSAMPLE);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic [OsW-1:0]  OsHalf  = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0]  OsLast  = OsW'(OVERSAMPLE - 1);

  if ((ClkFrequency % (OVERSAMPLE * Baud)) != 0) begin : g_bad_clk
    $error("ClkFrequency must be an exact multiple of 8*Baud");
  end

  // ---------------- transmitter ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [BitW-1:0] tx_bit_q, tx_bit_d;
  logic            tx_tick;

  uart_baud_gen #(.Div(BitDiv)) u_tx_baud (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (tx_state_q == TX_IDLE),
    .tick_o (tx_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    TxD        = 1'b1;
    TxD_busy   = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        TxD_busy = 1'b0;
        if (TxD_start) begin
          tx_shift_d = TxD_data;
          tx_bit_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        TxD = 1'b0;
        if (tx_tick) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        TxD = tx_shift_q[0];
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == BitLast) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  // ---------------- receiver ----------------
  // Synchronizer flops reset to the idle-high level so reset never looks like a start edge.
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= RxD;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [OsW-1:0]  rx_os_q, rx_os_d;
  logic [BitW-1:0] rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_ready_q, rx_ready_d;
  logic            rx_tick;
  logic            rx_start_det;

  assign rx_start_det = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_s2_q;

  uart_baud_gen #(.Div(OsDiv)) u_rx_baud (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (rx_state_q == RX_IDLE),
    .tick_o (rx_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_os_d    = rx_os_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_start_det) begin
          rx_os_d    = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 1'b1;
          if (rx_os_q == OsHalf) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 1'b1;
          if (rx_os_q == OsLast) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 1'b1;
            if (rx_bit_q == BitLast) rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_os_d = rx_os_q + 1'b1;
          if (rx_os_q == OsLast) begin
            if (rx_s2_q) begin
              rx_data_d  = rx_shift_q;
              rx_ready_d = 1'b1;
            end
            rx_state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_os_q    <= rx_os_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign RxD_data       = rx_data_q;
  assign RxD_data_ready = rx_ready_q;

`ifdef UART_RX_IDLE_EN
  localparam int unsigned GapClks = GAP_BITS * BitDiv;
  localparam int unsigned GapW    = $clog2(GapClks + 1);

  logic [GapW-1:0] gap_q, gap_d;
  logic            idle_q, idle_d;

  // Counter saturates at GapClks; idle stays set until the next start edge.
  always_comb begin
    gap_d  = '0;
    idle_d = idle_q;
    if ((rx_state_q == RX_IDLE) && rx_s2_q) begin
      gap_d = (gap_q == GapW'(GapClks)) ? gap_q : gap_q + 1'b1;
    end
    if (rx_start_det) idle_d = 1'b0;
    else if (gap_d == GapW'(GapClks)) idle_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q  <= '0;
      idle_q <= 1'b0;
    end else begin
      gap_q  <= gap_d;
      idle_q <= idle_d;
    end
  end

  assign RxD_idle = idle_q;
`else
  assign RxD_idle = 1'b0;
`endif

endmodule

// File: tb/tb_uart_async_transceiver.sv
// Directed bench for uart_async_transceiver: transmit, busy, receive, error, glitch, loopback, idle.
module tb_uart_async_transceiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       lb = 1'b0;
  logic       rxd_line;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_idle;
  logic       TxD_start = 1'b0;
  logic [7:0] TxD_data = 8'h00;
  logic       TxD;
  logic       TxD_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic [7:0] exp_q[$];

  assign rxd_line = lb ? TxD : rxd_drv;

  uart_async_transceiver #(.ClkFrequency(11059200), .Baud(115200)) dut (
    .clk            (clk),
    .rst            (rst),
    .RxD            (rxd_line),
    .RxD_data       (RxD_data),
    .RxD_data_ready (RxD_data_ready),
    .RxD_idle       (RxD_idle),
    .TxD_start      (TxD_start),
    .TxD_data       (TxD_data),
    .TxD            (TxD),
    .TxD_busy       (TxD_busy)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every cycle with ready high is logged, so a stretched pulse shows up as extra entries
  always @(negedge clk) begin
    if (!rst && RxD_data_ready) begin
      got_q.push_back(RxD_data);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx_frame(input logic [7:0] d, input logic stop_bit, output int t0);
    rxd_drv = 1'b0;
    t0 = cyc;
    ticks(96);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      ticks(96);
    end
    rxd_drv = stop_bit;
    ticks(96);
    rxd_drv = 1'b1;
    ticks(50);
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (TxD_busy === 1'b1 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1200) check(tag, 32'(TxD_busy), 32'd0);
  endtask

  initial begin
    int ones[10];
    logic [9:0] frame;
    int t0;
    int t_end;

    // reset
    ticks(5);
    check("rst_txd", 32'(TxD), 32'd1);
    check("rst_busy", 32'(TxD_busy), 32'd0);
    check("rst_rx_data", 32'(RxD_data), 32'h00);
    check("rst_rx_ready", 32'(RxD_data_ready), 32'd0);
    check("rst_rx_idle", 32'(RxD_idle), 32'd0);

    // transmit 0x55 on the first cycle out of reset; 0xA3 offered mid-frame must be ignored
    rst = 1'b0;
    TxD_data = 8'h55;
    TxD_start = 1'b1;
    @(negedge clk);
    TxD_start = 1'b0;
    foreach (ones[i]) ones[i] = 0;
    for (int k = 1; k <= 960; k++) begin
      if (TxD === 1'b1) ones[(k - 1) / 96]++;
      if (k == 1) check("tx_busy_rise", 32'(TxD_busy), 32'd1);
      if (k == 960) check("tx_busy_last", 32'(TxD_busy), 32'd1);
      if (k == 300) begin
        TxD_data = 8'hA3;
        TxD_start = 1'b1;
      end else if (k == 301) begin
        TxD_start = 1'b0;
      end
      @(negedge clk);
    end
    check("tx_busy_fall", 32'(TxD_busy), 32'd0);
    check("tx_idle_line", 32'(TxD), 32'd1);
    frame = 10'b1_0101_0101_0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d_high_cycles", i), 32'(ones[i]), frame[i] ? 32'd96 : 32'd0);
    end

    // receive 0x3C
    got_q.delete();
    got_cyc_q.delete();
    send_rx_frame(8'h3C, 1'b1, t0);
    check("rx_pulse_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      check("rx_pulse_data", 32'(got_q[0]), 32'h3C);
      check("rx_pulse_near_stop_mid",
            32'((got_cyc_q[0] >= t0 + 905) && (got_cyc_q[0] <= t0 + 925)), 32'd1);
    end
    check("rx_data_held", 32'(RxD_data), 32'h3C);

    // framing error: 0x7E with stop bit 0
    got_q.delete();
    got_cyc_q.delete();
    send_rx_frame(8'h7E, 1'b0, t0);
    check("ferr_no_pulse", 32'(got_q.size()), 32'd0);
    check("ferr_data_kept", 32'(RxD_data), 32'h3C);

    // 20-clock glitch
    rxd_drv = 1'b0;
    ticks(20);
    rxd_drv = 1'b1;
    ticks(200);
    check("glitch_no_pulse", 32'(got_q.size()), 32'd0);
    check("glitch_data_kept", 32'(RxD_data), 32'h3C);

    // loopback 0x00, 0xFF, 0x81 back-to-back
    lb = 1'b1;
    got_q.delete();
    got_cyc_q.delete();
    exp_q = '{8'h00, 8'hFF, 8'h81};
    foreach (exp_q[i]) begin
      wait_not_busy("lb_busy_timeout");
      TxD_data = exp_q[i];
      TxD_start = 1'b1;
      @(negedge clk);
      TxD_start = 1'b0;
    end
    wait_not_busy("lb_busy_timeout");
    t_end = cyc;
    ticks(100);
    check("lb_pulse_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("lb_data", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end

    // idle gap after the last loopback frame
    while (cyc < t_end + 1300) @(negedge clk);
    check("idle_before_gap", 32'(RxD_idle), 32'd0);
    while (cyc < t_end + 1650) @(negedge clk);
`ifdef UART_RX_IDLE_EN
    check("idle_after_gap", 32'(RxD_idle), 32'd1);
`else
    check("idle_after_gap", 32'(RxD_idle), 32'd0);
`endif
    lb = 1'b0;
    rxd_drv = 1'b0;
    ticks(10);
    check("idle_clear_on_start", 32'(RxD_idle), 32'd0);
    rxd_drv = 1'b1;
    ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
